// File: rtl/i2s_rx.sv
// i2s_rx: I2S master receiver for the microphone front end.
//
// Generates the I2S bit clock (sck_out) and word select (ws_out) from clk_in
// and deserializes the microphone's serial data line. Each complete frame
// (one left slot followed by one right slot) produces one PCM pair on
// left_out/right_out together with a single-cycle valid_out strobe.
//
// Ports:
//   clk_in     system clock
//   rst_n_in   asynchronous active-low reset
//   enable_in  run SCK/WS and capture when high; low discards a partial frame
//   sd_in      serial data from the mic (asynchronous to clk_in)
//   sck_out    I2S bit clock, period 2*SCK_DIV clk_in cycles
//   ws_out     I2S word select (0 = left, 1 = right)
//   left_out   last complete left sample (MSB-first, two's complement)
//   right_out  last complete right sample
//   valid_out  one-cycle pulse when a new left/right pair is presented
module i2s_rx #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_BITS    = 32,
  parameter int SCK_DIV      = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    enable_in,
  input  logic                    sd_in,
  output logic                    sck_out,
  output logic                    ws_out,
  output logic [SAMPLE_WIDTH-1:0] left_out,
  output logic [SAMPLE_WIDTH-1:0] right_out,
  output logic                    valid_out
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CNT_W      = $clog2(SCK_DIV);
  localparam int B_W        = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCK_DIV - 1);
  localparam logic [B_W-1:0]   B_LAST     = B_W'(FRAME_BITS - 1);
  localparam logic [B_W-1:0]   B_SLOT     = B_W'(SLOT_BITS);
  localparam logic [B_W-1:0]   B_SLOT_M1  = B_W'(SLOT_BITS - 1);
  localparam logic [B_W-1:0]   B_KEEP_LIM = B_W'(SAMPLE_WIDTH);

  logic                    sdMeta_q, sdSync_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sck_q, sck_d;
  logic                    ws_q, ws_d;
  logic [B_W-1:0]          bitIdx_q, bitIdx_d;
  logic [SAMPLE_WIDTH-1:0] leftShift_q, leftShift_d;
  logic [SAMPLE_WIDTH-1:0] rightShift_q, rightShift_d;
  logic [SAMPLE_WIDTH-1:0] leftOut_q, leftOut_d;
  logic [SAMPLE_WIDTH-1:0] rightOut_q, rightOut_d;
  logic                    valid_q, valid_d;

  logic                    cntLast;
  logic                    riseEvt;
  logic                    fallEvt;
  logic                    inRight;
  logic [B_W-1:0]          slotPos;
  logic                    keepBit;

  // Rise/fall events are the cycles whose closing edge toggles sck. They
  // are mutually exclusive because they depend on the current sck level.
  // Slot position 0 is the MSB; bits beyond SAMPLE_WIDTH are padding.
  assign cntLast = (cnt_q == CNT_LAST);
  assign riseEvt = enable_in && cntLast && !sck_q;
  assign fallEvt = enable_in && cntLast && sck_q;
  assign inRight = (bitIdx_q >= B_SLOT);
  assign slotPos = inRight ? (bitIdx_q - B_SLOT) : bitIdx_q;
  assign keepBit = (slotPos < B_KEEP_LIM);

  // Next-state logic. Dropping enable clears the frame machinery but keeps
  // the last published pair. The output update uses the post-capture shift
  // value so the final right bit is included when SAMPLE_WIDTH==SLOT_BITS.
  // ws is derived from the next bit index so it leads each slot MSB by one
  // SCK period.
  always_comb begin
    cnt_d        = cnt_q;
    sck_d        = sck_q;
    bitIdx_d     = bitIdx_q;
    leftShift_d  = leftShift_q;
    rightShift_d = rightShift_q;
    leftOut_d    = leftOut_q;
    rightOut_d   = rightOut_q;
    valid_d      = 1'b0;

    if (!enable_in) begin
      cnt_d        = '0;
      sck_d        = 1'b0;
      bitIdx_d     = '0;
      leftShift_d  = '0;
      rightShift_d = '0;
    end else begin
      if (cntLast) begin
        cnt_d = '0;
        sck_d = ~sck_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end

      if (fallEvt) begin
        bitIdx_d = (bitIdx_q == B_LAST) ? '0 : bitIdx_q + 1'b1;
      end

      if (riseEvt && keepBit) begin
        if (inRight) begin
          rightShift_d = SAMPLE_WIDTH'({rightShift_q, sdSync_q});
        end else begin
          leftShift_d = SAMPLE_WIDTH'({leftShift_q, sdSync_q});
        end
      end

      if (riseEvt && (bitIdx_q == B_LAST)) begin
        leftOut_d  = leftShift_d;
        rightOut_d = rightShift_d;
        valid_d    = 1'b1;
      end
    end

    ws_d = (bitIdx_d >= B_SLOT_M1) && (bitIdx_d != B_LAST);
  end

  // State registers, including the two-flop synchronizer for sd_in which
  // keeps running regardless of enable.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sdMeta_q     <= 1'b0;
      sdSync_q     <= 1'b0;
      cnt_q        <= '0;
      sck_q        <= 1'b0;
      ws_q         <= 1'b0;
      bitIdx_q     <= '0;
      leftShift_q  <= '0;
      rightShift_q <= '0;
      leftOut_q    <= '0;
      rightOut_q   <= '0;
      valid_q      <= 1'b0;
    end else begin
      sdMeta_q     <= sd_in;
      sdSync_q     <= sdMeta_q;
      cnt_q        <= cnt_d;
      sck_q        <= sck_d;
      ws_q         <= ws_d;
      bitIdx_q     <= bitIdx_d;
      leftShift_q  <= leftShift_d;
      rightShift_q <= rightShift_d;
      leftOut_q    <= leftOut_d;
      rightOut_q   <= rightOut_d;
      valid_q      <= valid_d;
    end
  end

  assign sck_out   = sck_q;
  assign ws_out    = ws_q;
  assign left_out  = leftOut_q;
  assign right_out = rightOut_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: bench for i2s_rx. Two instances run side by side from shared
// reset/enable: instance 0 at the default parameters (16/32/4) and
// instance 1 at SAMPLE_WIDTH=24, SLOT_BITS=32, SCK_DIV=3.
//
// Each instance has its own microphone model and reference model. The
// reference is expressed purely in terms of n, the number of clock edges
// since the receiver last started running:
//   sck toggles every SCK_DIV edges, b = n / (2*SCK_DIV) mod 64,
//   ws = ((b+1) mod 64) >= 32, valid when n mod (128*SCK_DIV) equals
//   127*SCK_DIV, and the pair published is the top SAMPLE_WIDTH bits of the
//   slot words the mic was given for that frame.
module tb_i2s_rx;

  localparam int NI   = 2;
  localparam int NF   = 4;
  localparam int SLOT = 32;

  logic clk = 1'b0;
  logic rstN;
  logic en;
  logic noise;
  logic pinActive;
  logic timeoutFlag;

  logic        sd0, sd1;
  logic        sck0, sck1, ws0, ws1, valid0, valid1;
  logic [15:0] left0, right0;
  logic [23:0] left1, right1;

  logic [31:0] micL [NI][NF];
  logic [31:0] micR [NI][NF];

  int          n [NI];
  logic        expSck [NI];
  logic        expWs [NI];
  logic        expValid [NI];
  logic [31:0] expLeft [NI];
  logic [31:0] expRight [NI];

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int validIdx [NI];
  int lastValid [NI];

  always #5 clk = ~clk;

  i2s_rx #(.SAMPLE_WIDTH(16), .SLOT_BITS(32), .SCK_DIV(4)) dut0 (
    .clk_in(clk), .rst_n_in(rstN), .enable_in(en), .sd_in(sd0),
    .sck_out(sck0), .ws_out(ws0), .left_out(left0), .right_out(right0),
    .valid_out(valid0)
  );

  i2s_rx #(.SAMPLE_WIDTH(24), .SLOT_BITS(32), .SCK_DIV(3)) dut1 (
    .clk_in(clk), .rst_n_in(rstN), .enable_in(en), .sd_in(sd1),
    .sck_out(sck1), .ws_out(ws1), .left_out(left1), .right_out(right1),
    .valid_out(valid1)
  );

  function automatic int widthOf(input int i);
    return (i == 0) ? 16 : 24;
  endfunction

  function automatic int divOf(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  // Hand-written literal pairs for the fixed frames loaded at start-up.
  function automatic logic [31:0] pinLeft(input int i, input int idx);
    if (i == 1) return 32'h0080_0001;
    case (idx)
      0: return 32'h0000_8001;
      1: return 32'h0000_1234;
      2: return 32'h0000_FFFF;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] pinRight(input int i, input int idx);
    if (i == 1) return 32'h007F_FFFE;
    case (idx)
      0: return 32'h0000_7FFE;
      1: return 32'h0000_ABCD;
      2: return 32'h0000_0000;
      default: return 32'h0000_FFFF;
    endcase
  endfunction

  // Reference model: advances the run counter on every running edge and
  // derives every expected output from it; reset clears immediately.
  always @(posedge clk or negedge rstN) begin
    int d, w, b, f;
    for (int i = 0; i < NI; i++) begin
      d = divOf(i);
      w = widthOf(i);
      if (!rstN) begin
        n[i]        = 0;
        expLeft[i]  = 32'h0;
        expRight[i] = 32'h0;
      end else if (!en) begin
        n[i] = 0;
      end else begin
        n[i] = n[i] + 1;
      end
      b           = (n[i] / (2 * d)) % (2 * SLOT);
      expSck[i]   = ((n[i] / d) % 2) == 1;
      expWs[i]    = ((b + 1) % (2 * SLOT)) >= SLOT;
      expValid[i] = (n[i] % (4 * SLOT * d)) == d * (4 * SLOT - 1);
      if (expValid[i]) begin
        f           = (n[i] / (4 * SLOT * d)) % NF;
        expLeft[i]  = micL[i][f] >> (32 - w);
        expRight[i] = micR[i][f] >> (32 - w);
      end
    end
  end

  // Microphone model: launches slot bit k after the edge that ends SCK
  // falling period k, MSB first, left slot then right slot. While noise is
  // set the line toggles randomly instead.
  always @(posedge clk) begin
    int k, f, p, d;
    logic v [NI];
    #1;
    for (int i = 0; i < NI; i++) begin
      d = divOf(i);
      if (noise) begin
        v[i] = 1'($urandom_range(0, 1));
      end else begin
        k = n[i] / (2 * d);
        f = (k / (2 * SLOT)) % NF;
        p = k % (2 * SLOT);
        v[i] = (p < SLOT) ? micL[i][f][31 - p] : micR[i][f][31 - (p - SLOT)];
      end
    end
    sd0 = v[0];
    sd1 = v[1];
  end

  task automatic checkOutput(input string name, input int inst,
                             input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s inst%0d cycle %0d: got 0x%0h, expected 0x%0h",
               name, inst, cycle, actual, expected);
    end
  endtask

  // Single compare process: every cycle, every output of both instances is
  // checked against the model; valid pulses additionally get a literal
  // spacing check and, for the start-up frames, literal data checks.
  always @(negedge clk) begin
    logic        aSck, aWs, aValid;
    logic [31:0] aL, aR;
    cycle++;
    for (int i = 0; i < NI; i++) begin
      if (i == 0) begin
        aSck = sck0; aWs = ws0; aValid = valid0;
        aL = 32'(left0); aR = 32'(right0);
      end else begin
        aSck = sck1; aWs = ws1; aValid = valid1;
        aL = 32'(left1); aR = 32'(right1);
      end
      checkOutput("sck", i, 32'(aSck), 32'(expSck[i]));
      checkOutput("ws", i, 32'(aWs), 32'(expWs[i]));
      checkOutput("valid", i, 32'(aValid), 32'(expValid[i]));
      checkOutput("left", i, aL, expLeft[i]);
      checkOutput("right", i, aR, expRight[i]);
      if (n[i] == 0) validIdx[i] = 0;
      if (aValid) begin
        if (validIdx[i] > 0)
          checkOutput("validGap", i, 32'(cycle - lastValid[i]), (i == 0) ? 32'd512 : 32'd384);
        if (pinActive && ((i == 0 && validIdx[i] < 4) || (i == 1 && validIdx[i] == 0))) begin
          checkOutput("pinLeft", i, aL, pinLeft(i, validIdx[i]));
          checkOutput("pinRight", i, aR, pinRight(i, validIdx[i]));
        end
        lastValid[i] = cycle;
        validIdx[i]  = validIdx[i] + 1;
      end
    end
    checkOutput("waitBound", 0, 32'(timeoutFlag), 32'h0);
  end

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  task automatic randomizeFrames();
    for (int i = 0; i < NI; i++)
      for (int f = 0; f < NF; f++) begin
        micL[i][f] = $urandom;
        micR[i][f] = $urandom;
      end
  endtask

  task automatic waitFor(input int inst, input int period, input int target);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (n[inst] % period == target) begin
        hit = 1'b1;
        break;
      end
      applyStimulus(1);
    end
    if (!hit) timeoutFlag = 1'b1;
  endtask

  initial begin
    rstN        = 1'b0;
    en          = 1'b0;
    noise       = 1'b1;
    pinActive   = 1'b0;
    timeoutFlag = 1'b0;
    for (int i = 0; i < NI; i++) begin
      validIdx[i]  = 0;
      lastValid[i] = 0;
    end
    randomizeFrames();
    micL[0][0] = 32'h8001_FFFF;
    micR[0][0] = 32'h7FFE_0000;
    micL[0][1] = {16'h1234, 16'($urandom)};
    micR[0][1] = {16'hABCD, 16'($urandom)};
    micL[0][2] = {16'hFFFF, 16'($urandom)};
    micR[0][2] = {16'h0000, 16'($urandom)};
    micL[0][3] = {16'h0000, 16'($urandom)};
    micR[0][3] = {16'hFFFF, 16'($urandom)};
    micL[1][0] = 32'h8000_01FF;
    micR[1][0] = 32'h7FFF_FE00;

    // Reset held with a noisy data line, then release with enable high.
    applyStimulus(12);
    noise     = 1'b0;
    en        = 1'b1;
    pinActive = 1'b1;
    applyStimulus(4);
    rstN = 1'b1;
    applyStimulus(4 * 512 + 40);
    pinActive = 1'b0;

    // Disable for 100 cycles while instance 0 is at b=20, new data after.
    waitFor(0, 512, 162);
    en = 1'b0;
    randomizeFrames();
    applyStimulus(100);
    en = 1'b1;
    applyStimulus(2 * 512 + 40);

    // Async reset while instance 1 is in its right slot.
    waitFor(1, 384, 300);
    rstN = 1'b0;
    applyStimulus(3);
    rstN = 1'b1;
    applyStimulus(2 * 512 + 40);

    // Random run lengths with short random disables and fresh data.
    for (int r = 0; r < 4; r++) begin
      en = 1'b0;
      randomizeFrames();
      applyStimulus($urandom_range(1, 20));
      en = 1'b1;
      applyStimulus($urandom_range(300, 1300));
    end
    applyStimulus(600);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
